// File: rtl/rx_frame_filter.sv
// Store-and-forward frame validator: SYNC ADDR LEN payload CHK in, ADDR LEN payload out; first m_valid 1 cycle after entering FWD.
// Input is stalled (s_ready=0) while forwarding; output holds m_data while m_valid && !m_ready.
module rx_frame_filter #(
  parameter int         MAX_LEN     = 64,
  parameter logic [7:0] SYNC_BYTE   = 8'h55,
  parameter int         TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       frame_ok,
  output logic       busy,
  output logic [7:0] err_chk_cnt,
  output logic [7:0] err_len_cnt,
  output logic [7:0] err_to_cnt
);

  localparam int DEPTH = MAX_LEN + 2;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW    = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {HUNT, ADDR, LEN, PAYLOAD, CHK, FWD} state_t;

  state_t        state, state_nxt;
  logic [7:0]    frame_buf [DEPTH];
  logic [7:0]    chk;
  logic [7:0]    len_q;
  logic [8:0]    idx;
  logic [8:0]    rd_end;
  logic [TW-1:0] to_cnt;
  logic          in_frame, timeout, acc;
  logic          len_bad, chk_bad, chk_good;

  assign in_frame = (state == ADDR) || (state == LEN) || (state == PAYLOAD) || (state == CHK);
  assign timeout  = in_frame && (to_cnt == TW'(TIMEOUT_CYC));
  assign s_ready  = !rst && (state != FWD) && !timeout;
  assign acc      = s_valid && s_ready;
  assign busy     = (state != HUNT);
  assign rd_end   = {1'b0, len_q} + 9'd2;

  always_comb begin
    state_nxt = state;
    len_bad   = 1'b0;
    chk_bad   = 1'b0;
    chk_good  = 1'b0;
    case (state)
      HUNT: if (acc && s_data == SYNC_BYTE) state_nxt = ADDR;
      ADDR: begin
        if (timeout) state_nxt = HUNT;
        else if (acc) state_nxt = LEN;
      end
      LEN: begin
        if (timeout) state_nxt = HUNT;
        else if (acc) begin
          if (s_data == 8'd0 || int'(s_data) > MAX_LEN) begin
            state_nxt = HUNT;
            len_bad   = 1'b1;
          end else begin
            state_nxt = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (timeout) state_nxt = HUNT;
        else if (acc && (idx + 9'd1) == {1'b0, len_q}) state_nxt = CHK;
      end
      CHK: begin
        if (timeout) state_nxt = HUNT;
        else if (acc) begin
          if (s_data == chk) begin
            state_nxt = FWD;
            chk_good  = 1'b1;
          end else begin
            state_nxt = HUNT;
            chk_bad   = 1'b1;
          end
        end
      end
      FWD: if (m_valid && m_ready && idx == rd_end) state_nxt = HUNT;
      default: state_nxt = HUNT;
    endcase
  end

  // Frame storage carries no reset; contents are only read after a full frame is written.
  always_ff @(posedge clk) begin
    if (acc) begin
      case (state)
        ADDR:    frame_buf[0] <= s_data;
        LEN:     frame_buf[1] <= s_data;
        PAYLOAD: frame_buf[AW'(idx + 9'd2)] <= s_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HUNT;
      m_valid     <= 1'b0;
      m_data      <= 8'h00;
      frame_ok    <= 1'b0;
      err_chk_cnt <= 8'h00;
      err_len_cnt <= 8'h00;
      err_to_cnt  <= 8'h00;
      to_cnt      <= '0;
      idx         <= '0;
      chk         <= 8'h00;
      len_q       <= 8'h00;
    end else begin
      state    <= state_nxt;
      frame_ok <= chk_good;

      if (acc || !in_frame || timeout) to_cnt <= '0;
      else                              to_cnt <= to_cnt + TW'(1);

      if (len_bad && err_len_cnt != 8'hFF) err_len_cnt <= err_len_cnt + 8'd1;
      if (chk_bad && err_chk_cnt != 8'hFF) err_chk_cnt <= err_chk_cnt + 8'd1;
      if (timeout && err_to_cnt != 8'hFF)  err_to_cnt  <= err_to_cnt + 8'd1;

      // idx is the payload write index while receiving and the read index while forwarding.
      case (state)
        ADDR: if (acc) chk <= s_data;
        LEN: if (acc) begin
          chk   <= chk ^ s_data;
          len_q <= s_data;
          idx   <= '0;
        end
        PAYLOAD: if (acc) begin
          chk <= chk ^ s_data;
          idx <= idx + 9'd1;
        end
        CHK: if (acc) idx <= '0;
        FWD: begin
          if ((!m_valid || m_ready) && idx != rd_end) begin
            m_data  <= frame_buf[AW'(idx)];
            m_valid <= 1'b1;
            idx     <= idx + 9'd1;
          end else if (m_ready) begin
            m_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
